// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with long-latency scoreboard and starvation aging.
// Optional forwarding outputs are enabled by defining RF_WB_FWD_EN.
module rf_wb_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 5,
    parameter int DW         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req_valid,
    input  logic [3*AW-1:0]   req_addr,
    input  logic [3*DW-1:0]   req_data,
    output logic [2:0]        req_ready,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_addr,
    input  logic [AW-1:0]     chk_addr0,
    input  logic [AW-1:0]     chk_addr1,
    output logic              hz_stall,
    output logic              rf_we,
    output logic [AW-1:0]     rf_wa,
    output logic [DW-1:0]     rf_wd,
`ifdef RF_WB_FWD_EN
    output logic              fwd_hit0,
    output logic              fwd_hit1,
    output logic [DW-1:0]     fwd_data0,
    output logic [DW-1:0]     fwd_data1,
`endif
    output logic              sb_err
);

    localparam int         NREG       = 1 << AW;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [AW-1:0] ZERO_A  = {AW{1'b0}};

    logic [3:0]      starve_r;
    logic [3:0]      starve_nxt_s;
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic            sb_err_r;
    logic            sb_err_nxt_s;
    logic            rf_we_r;
    logic [AW-1:0]   rf_wa_r;
    logic [DW-1:0]   rf_wd_r;
    logic [2:0]      grant_s;
    logic            aged_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_data_s;
    logic            wr_s;
    logic            hz_s;

    // Grant selection; the aged requester 2 jumps ahead once it has waited long enough.
    always_comb begin
        grant_s = 3'b000;
        aged_s  = req_valid[2] && (starve_r == STARVE_LIM);
        if (rst) begin
            grant_s = 3'b000;
        end else if (aged_s) begin
            grant_s = 3'b100;
        end else if (req_valid[0]) begin
            grant_s = 3'b001;
        end else if (req_valid[1]) begin
            grant_s = 3'b010;
        end else if (req_valid[2]) begin
            grant_s = 3'b100;
        end else begin
            grant_s = 3'b000;
        end
    end

    // Route the granted requester's address and data to the write command.
    always_comb begin
        sel_addr_s = ZERO_A;
        sel_data_s = {DW{1'b0}};
        case (grant_s)
            3'b001: begin
                sel_addr_s = req_addr[0*AW +: AW];
                sel_data_s = req_data[0*DW +: DW];
            end
            3'b010: begin
                sel_addr_s = req_addr[1*AW +: AW];
                sel_data_s = req_data[1*DW +: DW];
            end
            3'b100: begin
                sel_addr_s = req_addr[2*AW +: AW];
                sel_data_s = req_data[2*DW +: DW];
            end
            default: begin
                sel_addr_s = ZERO_A;
                sel_data_s = {DW{1'b0}};
            end
        endcase
        wr_s = (grant_s != 3'b000) && (sel_addr_s != ZERO_A);
    end

    // Next-state for starvation counter, scoreboard and sticky error.
    always_comb begin
        starve_nxt_s = 4'd0;
        busy_nxt_s   = busy_r;
        sb_err_nxt_s = sb_err_r;
        if (req_valid[2] && !grant_s[2]) begin
            starve_nxt_s = (starve_r == STARVE_LIM) ? starve_r : starve_r + 4'd1;
        end else begin
            starve_nxt_s = 4'd0;
        end
        if (grant_s[2]) begin
            busy_nxt_s[req_addr[2*AW +: AW]] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        // The set is applied after the clear so a fresh issue to the same register wins.
        if (iss_valid && (iss_addr != ZERO_A)) begin
            busy_nxt_s[iss_addr] = 1'b1;
            sb_err_nxt_s         = sb_err_r | busy_r[iss_addr];
        end else begin
            sb_err_nxt_s = sb_err_r;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Decode hazard detection against the registered scoreboard.
    always_comb begin
        hz_s = 1'b0;
        if ((chk_addr0 != ZERO_A) && busy_r[chk_addr0]) begin
            hz_s = 1'b1;
        end else if ((chk_addr1 != ZERO_A) && busy_r[chk_addr1]) begin
            hz_s = 1'b1;
        end else begin
            hz_s = 1'b0;
        end
    end

    // State registers and the write command held stable across the negedge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_r <= 4'd0;
            busy_r   <= {NREG{1'b0}};
            sb_err_r <= 1'b0;
            rf_we_r  <= 1'b0;
            rf_wa_r  <= ZERO_A;
            rf_wd_r  <= {DW{1'b0}};
        end else begin
            starve_r <= starve_nxt_s;
            busy_r   <= busy_nxt_s;
            sb_err_r <= sb_err_nxt_s;
            rf_we_r  <= wr_s;
            if (wr_s) begin
                rf_wa_r <= sel_addr_s;
                rf_wd_r <= sel_data_s;
            end else begin
                rf_wa_r <= rf_wa_r;
                rf_wd_r <= rf_wd_r;
            end
        end
    end

    assign req_ready = grant_s;
    assign hz_stall  = hz_s;
    assign rf_we     = rf_we_r;
    assign rf_wa     = rf_wa_r;
    assign rf_wd     = rf_wd_r;
    assign sb_err    = sb_err_r;

`ifdef RF_WB_FWD_EN
    // Forward the write in flight to decode operands that name it.
    always_comb begin
        fwd_hit0  = rf_we_r && (rf_wa_r == chk_addr0) && (chk_addr0 != ZERO_A);
        fwd_hit1  = rf_we_r && (rf_wa_r == chk_addr1) && (chk_addr1 != ZERO_A);
        fwd_data0 = rf_wd_r;
        fwd_data1 = rf_wd_r;
    end
`endif

endmodule
